// File: rtl/qdec_pkg.sv
// Shared types and widths for the quadrature position counter.
package qdec_pkg;
    localparam int QDEC_WIDTH = 32;
    typedef enum logic {QDEC_DOWN, QDEC_UP} qdec_dir_t;
endpackage

// File: rtl/quad_edge_detect.sv
// Samples encoder phases and reports phase-A transitions with direction.
module quad_edge_detect
    import qdec_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      phase_a,
    input  logic      phase_b,
    output logic      a_edge,
    output qdec_dir_t dir
);
    logic a_q, a_d;
    logic b_q, b_d;
    logic a_prev_q, a_prev_d;

    always_comb begin
        a_d      = phase_a;
        b_d      = phase_b;
        a_prev_d = a_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            a_prev_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            a_prev_q <= a_prev_d;
        end
    end

    // New A level matching B sampled alongside it means forward motion.
    always_comb begin
        a_edge = a_q ^ a_prev_q;
        dir    = (a_q == b_q) ? QDEC_UP : QDEC_DOWN;
    end
endmodule

// File: rtl/quadrature_decoder.sv
// Bus-mapped 2x quadrature position counter with load and tristate read.
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH = QDEC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe,
    input  logic             we,
    input  logic             ext_phase_a,
    input  logic             ext_phase_b,
    inout  wire  [WIDTH-1:0] data
);
    logic             a_edge;
    qdec_dir_t        dir;
    logic [WIDTH-1:0] count_q, count_d;

    quad_edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .phase_a (ext_phase_a),
        .phase_b (ext_phase_b),
        .a_edge  (a_edge),
        .dir     (dir)
    );

    // A bus load takes priority over a coincident encoder step.
    always_comb begin
        count_d = count_q;
        if (we)
            count_d = data;
        else if (a_edge && dir == QDEC_UP)
            count_d = count_q + 1'b1;
        else if (a_edge)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign data = (oe & ~we) ? count_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomised and directed check of the quadrature counter against a history model.
module tb_quadrature_decoder;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         oe  = 1'b0;
    logic         we  = 1'b0;
    logic         pa  = 1'b0;
    logic         pb  = 1'b0;
    logic         drv = 1'b0;
    logic [W-1:0] drv_val = '0;
    wire  [W-1:0] data;

    int n_cmp  = 0;
    int n_fail = 0;

    assign data = drv ? drv_val : {W{1'bz}};

    quadrature_decoder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .oe          (oe),
        .we          (we),
        .ext_phase_a (pa),
        .ext_phase_b (pb),
        .data        (data)
    );

    always #5 clk = ~clk;

    // Model: the last two phase samples (newest first) decide each step.
    logic [W-1:0] m_cnt;
    logic         ha[$];
    logic         hb[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = '0;
            ha = '{1'b0, 1'b0};
            hb = '{1'b0, 1'b0};
        end else begin
            if (we)
                m_cnt = drv_val;
            else if (ha[0] != ha[1])
                m_cnt = (ha[0] == hb[0]) ? m_cnt + 1 : m_cnt - 1;
            ha.push_front(pa);
            hb.push_front(pb);
            ha = ha[0:1];
            hb = hb[0:1];
        end
    end

    always @(negedge clk) begin
        if (!rst && !we) begin
            n_cmp++;
            if (oe) begin
                if (data !== m_cnt) begin
                    n_fail++;
                    $display("FAIL bus_read got %h want %h", data, m_cnt);
                end
            end else if (data !== {W{1'bz}}) begin
                n_fail++;
                $display("FAIL bus_idle got %h want Z", data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] exp);
        logic so;
        so = oe;
        oe = 1'b1;
        #1;
        n_cmp++;
        if (data !== exp || m_cnt !== exp) begin
            n_fail++;
            $display("FAIL %s got %h model %h want %h",
                     nm, data, m_cnt, exp);
        end
        oe = so;
    endtask

    task automatic load(input logic [W-1:0] v);
        we = 1'b1; drv = 1'b1; drv_val = v;
        tick();
        we = 1'b0; drv = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            pa = ~pa;
            tick();
            pb = ~pb;
            tick();
        end
    endtask

    task automatic settle(input logic a, input logic b);
        pa = a; pb = b;
        repeat (3) tick();
    endtask

    initial begin
        #2;
        chk("reset_zero", 32'h0);
        oe = 1'b0;
        #4;
        rst = 1'b0;
        tick();

        settle(1'b0, 1'b1);
        steps(254);
        chk("count_up_fe", 32'h0000_00FE);

        settle(1'b0, 1'b0);
        steps(254);
        chk("count_down_0", 32'h0);

        load(32'h0000_ABCD);
        chk("load_abcd", 32'h0000_ABCD);
        #1;
        n_cmp++;
        if (data !== {W{1'bz}}) begin
            n_fail++;
            $display("FAIL idle_z got %h want Z", data);
        end

        settle(1'b0, 1'b0);
        load(32'h0);
        steps(1);
        chk("underflow", 32'hFFFF_FFFF);

        settle(1'b0, 1'b1);
        load(32'hFFFF_FFFF);
        steps(1);
        chk("overflow", 32'h0);

        // A sampled now; the next edge sees a_edge together with the load.
        pa = ~pa;
        tick();
        load(32'h10);
        chk("load_beats_edge", 32'h10);

        steps(3);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst", 32'h0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) pa = ~pa;
            if ($urandom_range(0, 2) == 0) pb = ~pb;
            oe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                we = 1'b1; drv = 1'b1;
                drv_val = $urandom();
                if ($urandom_range(0, 1) == 1)
                    drv_val = 32'hFFFF_FFFF;
            end else begin
                we = 1'b0; drv = 1'b0;
            end
            tick();
        end
        we = 1'b0; drv = 1'b0;
        tick();
        chk("rand_end", m_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
